// File: rtl/accum_warp_index_sequencer.sv
// Accumulate-path warp/config-id index sequencer.
// Expands one block descriptor into a stream of (id, warp, block offset,
// block-local offset) items. Disabled ids are skipped combinationally, so
// skipping costs no cycles. Degenerate descriptors are dropped with a pulse.
module accum_warp_index_sequencer #(
    parameter int N_CFG    = 4,
    parameter int VDIM     = 2,
    parameter int WBW      = 16,
    parameter int VSIZE    = 32,
    parameter int MAX_WARP = 32,
    localparam int NCFG_BW = $clog2(N_CFG + 1),
    localparam int CCV_BW  = $clog2($clog2(VSIZE) + 1),
    localparam int WID_BW  = $clog2(MAX_WARP)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     src_rdy,
    output logic                     src_ack,
    input  logic [VDIM*WBW-1:0]      i_bofs,
    input  logic [VDIM*WBW-1:0]      i_aofs,
    input  logic [VDIM*WBW-1:0]      i_alofs,
    input  logic [VDIM*WBW-1:0]      i_bgrid_step,
    input  logic [VDIM*CCV_BW-1:0]   i_bsub_up_order,
    input  logic [VDIM*CCV_BW-1:0]   i_bsub_lo_order,
    input  logic [NCFG_BW-1:0]       i_id_beg,
    input  logic [NCFG_BW-1:0]       i_id_end,
    input  logic [NCFG_BW-1:0]       i_id_ret,
    input  logic [N_CFG-1:0]         i_id_mask,
    input  logic                     i_id_outer,
    input  logic                     i_islast,
    output logic                     dst_rdy,
    input  logic                     dst_ack,
    output logic [NCFG_BW-1:0]       o_id,
    output logic [WID_BW-1:0]        o_warpid,
    output logic [VDIM*WBW-1:0]      o_bofs,
    output logic [VDIM*WBW-1:0]      o_blofs,
    output logic [VDIM*WBW-1:0]      o_aofs,
    output logic [VDIM*WBW-1:0]      o_alofs,
    output logic                     o_retire,
    output logic                     o_islast,
    output logic                     o_drop,
    output logic                     o_warp_ovf
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                        state;
    logic [VDIM-1:0][WBW-1:0]      beg_q, cur_q;
    logic [VDIM-1:0][WBW:0]        end_q;
    logic [VDIM-1:0][CCV_BW-1:0]   up_q, lo_q;
    logic [N_CFG-1:0]              en_q;
    logic [NCFG_BW-1:0]            id_q, ret_q;
    logic                          outer_q, islast_q;
    logic [WID_BW-1:0]             wcnt_q;
    logic                          ovf_q, drop_q;
    logic [VDIM*WBW-1:0]           aofs_q, alofs_q;

    logic [VDIM-1:0][WBW-1:0]      in_beg;
    logic [VDIM-1:0][WBW:0]        in_end;
    logic [N_CFG-1:0]              in_en;
    logic                          in_degen;
    logic [NCFG_BW-1:0]            in_first;

    logic [VDIM-1:0]               dim_last;
    logic                          last_warp;
    logic [VDIM-1:0][WBW-1:0]      cur_nxt;
    logic                          carry;
    logic [N_CFG-1:0]              en_above;
    logic                          last_id;
    logic [NCFG_BW-1:0]            next_id, first_id;
    logic                          wcnt_wrap;
    logic [WID_BW-1:0]             wcnt_nxt;

    function automatic logic [NCFG_BW-1:0] lowest_set(input logic [N_CFG-1:0] m);
        logic [NCFG_BW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N_CFG; i++) begin
            if (m[N_CFG-1-i]) r = NCFG_BW'(N_CFG-1-i);
        end
        return r;
    endfunction

    function automatic logic [WBW-1:0] vshuf(input logic [WBW-1:0] x,
                                             input logic [CCV_BW-1:0] up,
                                             input logic [CCV_BW-1:0] lo);
        logic [WBW-1:0] lm;
        lm = '1;
        lm = lm << lo;
        return (x & ~lm) | ((x & lm) << up);
    endfunction

    // Descriptor decode: scaled range per dim, enabled id set, degeneracy
    always_comb begin
        in_beg   = '0;
        in_end   = '0;
        in_en    = '0;
        in_degen = 1'b0;
        for (int unsigned k = 0; k < VDIM; k++) begin
            in_beg[k] = i_bofs[k*WBW +: WBW] >> i_bsub_up_order[k*CCV_BW +: CCV_BW];
            in_end[k] = ({1'b0, i_bofs[k*WBW +: WBW]} + {1'b0, i_bgrid_step[k*WBW +: WBW]})
                        >> i_bsub_up_order[k*CCV_BW +: CCV_BW];
            if (in_end[k] <= {1'b0, in_beg[k]}) in_degen = 1'b1;
        end
        for (int unsigned j = 0; j < N_CFG; j++) begin
            in_en[j] = i_id_mask[j] && (NCFG_BW'(j) >= i_id_beg) && (NCFG_BW'(j) < i_id_end);
        end
        if (in_en == '0) in_degen = 1'b1;
        in_first = lowest_set(in_en);
    end

    // Warp position: ND counter with the highest dim fastest, plus linear count
    always_comb begin
        dim_last = '0;
        cur_nxt  = cur_q;
        carry    = 1'b1;
        for (int unsigned k = 0; k < VDIM; k++) begin
            dim_last[k] = (({1'b0, cur_q[k]} + (WBW+1)'(1)) == end_q[k]);
        end
        for (int unsigned i = 0; i < VDIM; i++) begin
            if (carry) begin
                if (dim_last[VDIM-1-i]) begin
                    cur_nxt[VDIM-1-i] = beg_q[VDIM-1-i];
                end else begin
                    cur_nxt[VDIM-1-i] = cur_q[VDIM-1-i] + WBW'(1);
                    carry = 1'b0;
                end
            end
        end
        last_warp = &dim_last;
        wcnt_wrap = (wcnt_q == WID_BW'(MAX_WARP-1));
        wcnt_nxt  = wcnt_wrap ? '0 : wcnt_q + WID_BW'(1);
    end

    // Id stepping: next enabled id above the current one, or wrap to the first
    always_comb begin
        en_above = '0;
        for (int unsigned j = 0; j < N_CFG; j++) begin
            en_above[j] = en_q[j] && (NCFG_BW'(j) > id_q);
        end
        last_id  = (en_above == '0);
        next_id  = lowest_set(en_above);
        first_id = lowest_set(en_q);
    end

    // Shuffled block and block-local offsets of the current position
    always_comb begin
        o_bofs  = '0;
        o_blofs = '0;
        for (int unsigned k = 0; k < VDIM; k++) begin
            o_bofs[k*WBW +: WBW]  = vshuf(cur_q[k], up_q[k], lo_q[k]);
            o_blofs[k*WBW +: WBW] = vshuf(cur_q[k] - beg_q[k], up_q[k], lo_q[k]);
        end
    end

    assign src_ack    = (state == IDLE) && src_rdy;
    assign dst_rdy    = (state == RUN);
    assign o_id       = id_q;
    assign o_warpid   = wcnt_q;
    assign o_aofs     = aofs_q;
    assign o_alofs    = alofs_q;
    assign o_retire   = dst_rdy && last_warp && (id_q < ret_q);
    assign o_islast   = dst_rdy && last_warp && last_id && islast_q;
    assign o_drop     = drop_q;
    assign o_warp_ovf = ovf_q;

    // Sequencer FSM: descriptor capture in IDLE, item stepping in RUN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            beg_q    <= '0;
            end_q    <= '0;
            cur_q    <= '0;
            up_q     <= '0;
            lo_q     <= '0;
            en_q     <= '0;
            id_q     <= '0;
            ret_q    <= '0;
            outer_q  <= 1'b0;
            islast_q <= 1'b0;
            wcnt_q   <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
            aofs_q   <= '0;
            alofs_q  <= '0;
        end else begin
            drop_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (src_rdy) begin
                        beg_q    <= in_beg;
                        end_q    <= in_end;
                        cur_q    <= in_beg;
                        up_q     <= i_bsub_up_order;
                        lo_q     <= i_bsub_lo_order;
                        en_q     <= in_en;
                        id_q     <= in_first;
                        ret_q    <= i_id_ret;
                        outer_q  <= i_id_outer;
                        islast_q <= i_islast;
                        aofs_q   <= i_aofs;
                        alofs_q  <= i_alofs;
                        wcnt_q   <= '0;
                        ovf_q    <= 1'b0;
                        if (in_degen) drop_q <= 1'b1;
                        else          state  <= RUN;
                    end
                end
                RUN: begin
                    if (dst_ack) begin
                        if (!outer_q) begin
                            // id innermost: warp steps only when the id set wraps
                            if (!last_id) begin
                                id_q <= next_id;
                            end else begin
                                id_q <= first_id;
                                if (last_warp) begin
                                    state <= IDLE;
                                end else begin
                                    cur_q  <= cur_nxt;
                                    wcnt_q <= wcnt_nxt;
                                    if (wcnt_wrap) ovf_q <= 1'b1;
                                end
                            end
                        end else begin
                            // warp innermost: warp restarts at beg for each new id
                            if (!last_warp) begin
                                cur_q  <= cur_nxt;
                                wcnt_q <= wcnt_nxt;
                                if (wcnt_wrap) ovf_q <= 1'b1;
                            end else begin
                                cur_q  <= beg_q;
                                wcnt_q <= '0;
                                if (last_id) state <= IDLE;
                                else         id_q  <= next_id;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_warp_index_sequencer.sv
// Bench for accum_warp_index_sequencer: directed table, hand sequences for
// stall / drop / overflow / async reset, and random descriptors against a
// list-based reference model.
module tb_accum_warp_index_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        src_rdy, src_ack;
    logic [31:0] i_bofs, i_aofs, i_alofs, i_bgrid_step;
    logic [5:0]  i_bsub_up_order, i_bsub_lo_order;
    logic [2:0]  i_id_beg, i_id_end, i_id_ret;
    logic [3:0]  i_id_mask;
    logic        i_id_outer, i_islast;
    logic        dst_rdy, dst_ack;
    logic [2:0]  o_id;
    logic [4:0]  o_warpid;
    logic [31:0] o_bofs, o_blofs, o_aofs, o_alofs;
    logic        o_retire, o_islast, o_drop, o_warp_ovf;

    accum_warp_index_sequencer #(.N_CFG(4), .VDIM(2), .WBW(16), .VSIZE(32), .MAX_WARP(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .src_rdy(src_rdy), .src_ack(src_ack),
        .i_bofs(i_bofs), .i_aofs(i_aofs), .i_alofs(i_alofs), .i_bgrid_step(i_bgrid_step),
        .i_bsub_up_order(i_bsub_up_order), .i_bsub_lo_order(i_bsub_lo_order),
        .i_id_beg(i_id_beg), .i_id_end(i_id_end), .i_id_ret(i_id_ret), .i_id_mask(i_id_mask),
        .i_id_outer(i_id_outer), .i_islast(i_islast), .dst_rdy(dst_rdy), .dst_ack(dst_ack),
        .o_id(o_id), .o_warpid(o_warpid), .o_bofs(o_bofs), .o_blofs(o_blofs),
        .o_aofs(o_aofs), .o_alofs(o_alofs), .o_retire(o_retire), .o_islast(o_islast),
        .o_drop(o_drop), .o_warp_ovf(o_warp_ovf)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] bofs, step, aofs, alofs;
        logic [5:0]  up, lo;
        logic [2:0]  beg, en, ret;
        logic [3:0]  mask;
        logic        outer, islast;
    } desc_t;

    typedef struct {
        desc_t d;
        bit    exp_drop;
        int    exp_ret;
        int    exp_isl;
    } vec_t;

    logic [138:0] act_item;
    assign act_item = {o_id, o_warpid, o_bofs, o_blofs, o_aofs, o_alofs, o_retire, o_islast, o_warp_ovf};

    logic [138:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int ret_cnt, isl_cnt;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int vs(input int v, input int u, input int l);
        int lm;
        lm = (32'hFFFF << l) & 32'hFFFF;
        return ((v & ~lm) | ((v & lm) << u)) & 32'hFFFF;
    endfunction

    function automatic desc_t mkd(input logic [31:0] bofs, input logic [31:0] step,
                                  input logic [5:0] up, input logic [5:0] lo,
                                  input logic [2:0] beg, input logic [2:0] en, input logic [2:0] ret,
                                  input logic [3:0] mask, input logic outer, input logic islast);
        desc_t d;
        d.bofs = bofs; d.step = step; d.up = up; d.lo = lo;
        d.beg = beg; d.en = en; d.ret = ret; d.mask = mask;
        d.outer = outer; d.islast = islast;
        d.aofs = 32'h1234_5678; d.alofs = 32'h0abc_0def;
        return d;
    endfunction

    // Reference: list the enabled ids and the linear warp range, then emit
    // every (warp, id) pair in the requested loop order.
    task automatic build(input desc_t d, output bit degen);
        int b[2], x[2], u[2], l[2];
        int ids[$];
        int bv, sv, nw, ni, w, n, rem, c, id;
        bit ovf;
        logic [31:0] bo, bl;
        logic [138:0] it;
        exp_q.delete();
        degen = 0;
        for (int k = 0; k < 2; k++) begin
            u[k] = d.up[k*3 +: 3];
            l[k] = d.lo[k*3 +: 3];
            bv = d.bofs[k*16 +: 16];
            sv = d.step[k*16 +: 16];
            b[k] = bv >> u[k];
            x[k] = ((bv + sv) >> u[k]) - b[k];
            if (x[k] <= 0) degen = 1;
        end
        for (int j = 0; j < 4; j++)
            if (d.mask[j] && j >= int'(d.beg) && j < int'(d.en)) ids.push_back(j);
        if (ids.size() == 0) degen = 1;
        if (degen) return;
        ni = ids.size();
        nw = x[0] * x[1];
        ovf = 0;
        for (int t = 0; t < nw * ni; t++) begin
            if (!d.outer) begin w = t / ni; n = t % ni; end
            else          begin n = t / nw; w = t % nw; end
            id = ids[n];
            if (w >= 32) ovf = 1;
            rem = w;
            bo = '0; bl = '0;
            for (int k = 1; k >= 0; k--) begin
                c = b[k] + rem % x[k];
                rem = rem / x[k];
                bo[k*16 +: 16] = 16'(vs(c, u[k], l[k]));
                bl[k*16 +: 16] = 16'(vs(c - b[k], u[k], l[k]));
            end
            it = {3'(id), 5'(w % 32), bo, bl, d.aofs, d.alofs,
                  (w == nw-1) && (id < int'(d.ret)),
                  (n == ni-1) && (w == nw-1) && d.islast, ovf};
            exp_q.push_back(it);
        end
    endtask

    task automatic drive_desc(input desc_t d);
        i_bofs = d.bofs; i_bgrid_step = d.step; i_aofs = d.aofs; i_alofs = d.alofs;
        i_bsub_up_order = d.up; i_bsub_lo_order = d.lo;
        i_id_beg = d.beg; i_id_end = d.en; i_id_ret = d.ret; i_id_mask = d.mask;
        i_id_outer = d.outer; i_islast = d.islast;
    endtask

    task automatic accept(input desc_t d);
        @(negedge i_clk);
        drive_desc(d);
        src_rdy = 1'b1;
        #1 chk("src_ack", src_ack, 1);
        @(posedge i_clk);
        #1 src_rdy = 1'b0;
    endtask

    // Called at the negedge of the first RUN cycle; checks every cycle
    task automatic consume(input int prob, input int stall_at, input int stop);
        int i, cyc, stall;
        bit ack;
        i = 0; cyc = 0; stall = 0;
        while (1) begin
            chk("dst_rdy", dst_rdy, 1);
            chk("item", act_item, exp_q[i]);
            src_rdy = 1'b1;
            #1 chk("src_ack_in_run", src_ack, 0);
            src_rdy = 1'b0;
            if (i == stall_at && stall < 5) begin ack = 0; stall++; end
            else ack = ($urandom_range(0, 99) < prob);
            dst_ack = ack;
            if (ack) begin
                if (o_retire) ret_cnt++;
                if (o_islast) isl_cnt++;
                i++;
            end
            if (i >= stop) break;
            cyc++;
            if (cyc > 3000) begin
                n_tests++; n_fail++;
                $display("FAIL consume_timeout: got %0d items expected %0d", i, stop);
                break;
            end
            @(negedge i_clk);
        end
        @(posedge i_clk);
        #1 dst_ack = 1'b0;
    endtask

    task automatic run_vec(input desc_t d, input bit exp_drop, input int exp_ret, input int exp_isl,
                           input bit cnt_chk, input int prob, input int stall_at);
        bit degen;
        build(d, degen);
        if (!cnt_chk) exp_drop = degen;
        accept(d);
        @(negedge i_clk);
        chk("o_drop", o_drop, exp_drop);
        if (exp_drop || exp_q.size() == 0) begin
            chk("drop_no_rdy", dst_rdy, 0);
        end else begin
            ret_cnt = 0; isl_cnt = 0;
            consume(prob, stall_at, exp_q.size());
            @(negedge i_clk);
            chk("back_idle", {dst_rdy, o_drop}, 0);
            if (cnt_chk) begin
                chk("retire_cnt", ret_cnt, exp_ret);
                chk("islast_cnt", isl_cnt, exp_isl);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t  tbl[6];
        desc_t d;
        bit    dg;

        tbl[0] = '{mkd(32'h0, {16'd2, 16'd4}, {3'd1, 3'd1}, 6'd0, 3'd0, 3'd3, 3'd2, 4'hF, 1'b0, 1'b1), 1'b0, 2, 1};
        tbl[1] = '{mkd(32'h0, {16'd2, 16'd4}, {3'd1, 3'd1}, 6'd0, 3'd0, 3'd3, 3'd2, 4'hF, 1'b1, 1'b0), 1'b0, 2, 0};
        tbl[2] = '{mkd(32'h0, {16'd1, 16'd1}, 6'd0, 6'd0, 3'd0, 3'd4, 3'd4, 4'b0101, 1'b0, 1'b1), 1'b0, 2, 1};
        tbl[3] = '{mkd(32'h0, {16'd2, 16'd0}, {3'd1, 3'd1}, 6'd0, 3'd0, 3'd3, 3'd2, 4'hF, 1'b0, 1'b1), 1'b1, 0, 0};
        tbl[4] = '{mkd(32'h0, {16'd2, 16'd4}, {3'd1, 3'd1}, 6'd0, 3'd0, 3'd3, 3'd2, 4'h0, 1'b0, 1'b1), 1'b1, 0, 0};
        tbl[5] = '{mkd({16'd3, 16'd5}, {16'd4, 16'd6}, {3'd2, 3'd0}, {3'd2, 3'd1}, 3'd1, 3'd3, 3'd0, 4'b1110, 1'b0, 1'b0), 1'b0, 0, 0};

        i_rst_n = 1'b0; src_rdy = 1'b0; dst_ack = 1'b0;
        drive_desc('0);
        repeat (2) @(negedge i_clk);
        chk("reset_outs", {dst_rdy, src_ack, o_drop, act_item}, 0);
        i_rst_n = 1'b1;

        for (int t = 0; t < 6; t++)
            run_vec(tbl[t].d, tbl[t].exp_drop, tbl[t].exp_ret, tbl[t].exp_isl, 1'b1, 100, -1);

        // consumer stalls 5 cycles on the third item
        run_vec(tbl[0].d, 1'b0, 2, 1, 1'b1, 100, 2);

        // degenerate descriptor, next one presented during the drop cycle
        build(tbl[3].d, dg);
        accept(tbl[3].d);
        build(tbl[0].d, dg);
        @(negedge i_clk);
        drive_desc(tbl[0].d);
        src_rdy = 1'b1;
        #1;
        chk("drop_pulse", o_drop, 1);
        chk("drop_no_rdy2", dst_rdy, 0);
        chk("accept_after_drop", src_ack, 1);
        @(posedge i_clk);
        #1 src_rdy = 1'b0;
        @(negedge i_clk);
        chk("drop_clears", o_drop, 0);
        ret_cnt = 0; isl_cnt = 0;
        consume(100, -1, exp_q.size());
        @(negedge i_clk);
        chk("back_idle2", {dst_rdy, o_drop}, 0);

        // random descriptors
        for (int r = 0; r < 40; r++) begin
            d = mkd({16'($urandom_range(0, 5)), 16'($urandom_range(0, 5))},
                    {16'($urandom_range(0, 5)), 16'($urandom_range(0, 5))},
                    {3'($urandom_range(0, 2)), 3'($urandom_range(0, 2))},
                    {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))},
                    3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            d.aofs = $urandom;
            d.alofs = $urandom;
            run_vec(d, 1'b0, 0, 0, 1'b0, 70, -1);
        end

        // 34 warps: warpid wraps, overflow flag, then async reset mid-RUN
        d = mkd(32'h0, {16'd34, 16'd1}, 6'd0, 6'd0, 3'd0, 3'd1, 3'd1, 4'b0001, 1'b0, 1'b1);
        build(d, dg);
        accept(d);
        @(negedge i_clk);
        consume(100, -1, 33);
        @(negedge i_clk);
        chk("ovf_item", act_item, exp_q[33]);
        chk("ovf_set", o_warp_ovf, 1);
        chk("warpid_wrap", o_warpid, 1);
        #2 i_rst_n = 1'b0;
        #1 chk("async_rst", {dst_rdy, src_ack, o_drop, act_item}, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_vec(tbl[2].d, 1'b0, 2, 1, 1'b1, 100, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
